// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Handshake: `start` is accepted on a rising edge whenever `busy` is low
// (IDLE or DONE). `busy` is high while iterating. `done` pulses for one cycle
// when `result` is loaded, and `result` holds until the next `done`.
// A multiply is a radix-2 shift-add and a divide is a restoring divide. Each
// takes 32 cycles. Divide-by-zero and signed overflow finish in one cycle.
`timescale 1ns/1ps
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t state;
    state_t state_next;

    logic [2:0]        op_q;
    logic [XLEN-1:0]   mag_a_q;
    logic [XLEN-1:0]   mag_b_q;
    logic              neg_a_q;
    logic              neg_b_q;
    logic [4:0]        cnt;
    logic [2*XLEN-1:0] acc;

    // Decode of the incoming request
    logic            accept;
    logic            a_signed_in;
    logic            b_signed_in;
    logic            neg_a_in;
    logic            neg_b_in;
    logic [XLEN-1:0] mag_a_in;
    logic [XLEN-1:0] mag_b_in;
    logic            div_zero_in;
    logic            ovf_in;
    logic            special_in;
    logic [XLEN-1:0] special_res;

    assign accept      = start && (state != S_CALC);
    assign a_signed_in = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign b_signed_in = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign neg_a_in    = a_signed_in && a[XLEN-1];
    assign neg_b_in    = b_signed_in && b[XLEN-1];
    assign mag_a_in    = neg_a_in ? -a : a;
    assign mag_b_in    = neg_b_in ? -b : b;
    assign div_zero_in = op[2] && (b == '0);
    assign ovf_in      = op[2] && !op[0] && (a == MIN_INT) && (b == '1);
    assign special_in  = div_zero_in || ovf_in;
    // op[1] separates REM/REMU from DIV/DIVU.
    assign special_res = div_zero_in ? (op[1] ? a : '1) : (op[1] ? '0 : MIN_INT);

    // One iteration step. The accumulator is {hi, lo}: for a multiply, lo
    // starts as the multiplier and is shifted out while the product fills
    // in from the top. For a divide, hi is the remainder and lo shifts the
    // dividend out while the quotient bits shift in.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] acc_next;

    assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a_q} : '0);
    assign mul_next  = {mul_sum, acc[XLEN-1:1]};
    assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, mag_b_q};
    assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
    assign acc_next  = op_q[2] ? div_next : mul_next;

    // Sign correction and result selection from the final step
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   final_res;

    assign prod_fix  = (neg_a_q ^ neg_b_q) ? -acc_next : acc_next;
    assign quo_fix   = (neg_a_q ^ neg_b_q) ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    assign rem_fix   = neg_a_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
    assign final_res = op_q[2] ? (op_q[1] ? rem_fix : quo_fix)
                               : ((op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                                       : prod_fix[2*XLEN-1:XLEN]);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_next = special_in ? S_DONE : S_CALC;
                else       state_next = S_IDLE;
            end
            S_CALC:  if (cnt == 5'd31) state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state == S_CALC);
        done = (state == S_DONE);
    end

    // Operand latch, iteration datapath and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            mag_a_q <= '0;
            mag_b_q <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            result  <= '0;
        end else if (accept) begin
            op_q    <= op;
            mag_a_q <= mag_a_in;
            mag_b_q <= mag_b_in;
            neg_a_q <= neg_a_in;
            neg_b_q <= neg_b_in;
            cnt     <= '0;
            acc     <= {{XLEN{1'b0}}, (op[2] ? mag_a_in : mag_b_in)};
            if (special_in) result <= special_res;
        end else if (state == S_CALC) begin
            acc <= acc_next;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) result <= final_res;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit latency, results, special
// cases, ignored starts, back-to-back issue and asynchronous reset.
`timescale 1ns/1ps
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request, let one edge accept it, then scramble the operands.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 3'($urandom_range(0, 7));
    endtask

    // Count edges until done, sampling 1ns after each edge (bounded).
    task automatic wait_done(output int lat, output int busy_bad, output int overlap);
        lat      = -1;
        busy_bad = 0;
        overlap  = 0;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (busy && done) overlap++;
            if (done) begin
                lat = i;
                break;
            end
            if (!busy) busy_bad++;
        end
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
        int lat, bb, ov;
        issue(o, x, y);
        wait_done(lat, bb, ov);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_result"}, result, exp);
        chk({tag, "_busy_gap"}, bb, 0);
        chk({tag, "_busy_done_overlap"}, ov, 0);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, {31'b0, done}, 0);
        chk({tag, "_busy_idle"}, {31'b0, busy}, 0);
        chk({tag, "_result_hold"}, result, exp);
    endtask

    initial begin
        int lat, bb, ov;
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        a     = '0;
        b     = '0;
        #12;
        chk("reset_busy", {31'b0, busy}, 0);
        chk("reset_done", {31'b0, done}, 0);
        chk("reset_result", result, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Multiplies
        run("mul_5x4",     3'b000, 32'd5,          32'd4,          32'h0000_0014, 32);
        run("mul_neg3x5",  3'b000, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1, 32);
        run("mulh_min",    3'b001, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32);
        run("mulhsu_ones", 3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32);
        run("mulhu_ones",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32);

        // Divides
        run("div_m7_2",    3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 32);
        run("rem_m7_2",    3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 32);
        run("divu_big",    3'b101, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC, 32);
        run("div_7_m2",    3'b100, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD, 32);
        run("rem_7_m2",    3'b110, 32'd7,          32'hFFFF_FFFE,  32'h0000_0001, 32);

        // Special cases
        run("divu_zero",   3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF, 0);
        run("remu_zero",   3'b111, 32'd5,          32'd0,          32'h0000_0005, 0);
        run("div_ovf",     3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 0);
        run("rem_ovf",     3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 0);

        // Start during CALC is ignored
        issue(3'b000, 32'd5, 32'd4);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1;
        op    = 3'b100;
        a     = 32'd9;
        b     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 32'h0000_1234;
        b     = 32'h0000_0000;
        chk("ign_busy", {31'b0, busy}, 1);
        wait_done(lat, bb, ov);
        chk("ign_latency", lat, 26);
        chk("ign_result", result, 32'h0000_0014);
        chk("ign_busy_gap", bb, 0);

        // Back-to-back: new request accepted on the edge leaving DONE
        issue(3'b100, 32'd9, 32'd3);
        chk("b2b_busy", {31'b0, busy}, 1);
        chk("b2b_done_low", {31'b0, done}, 0);
        chk("b2b_result_hold", result, 32'h0000_0014);
        wait_done(lat, bb, ov);
        chk("b2b_latency", lat, 32);
        chk("b2b_result", result, 32'h0000_0003);
        chk("b2b_busy_gap", bb, 0);
        @(posedge clk);
        #1;
        chk("b2b_done_pulse", {31'b0, done}, 0);

        // Asynchronous reset in the middle of a divide
        issue(3'b100, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #3;
        chk("pre_rst_busy", {31'b0, busy}, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_busy", {31'b0, busy}, 0);
        chk("async_rst_done", {31'b0, done}, 0);
        chk("async_rst_result", result, 0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_busy", {31'b0, busy}, 0);
        chk("post_rst_done", {31'b0, done}, 0);
        run("mul_6x7", 3'b000, 32'd6, 32'd7, 32'h0000_002A, 32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit for the single-core RISC-V datapath. It sits directly downstream of the register file: it consumes the two read-port operands (RD1, RD2) for an M-extension instruction and produces a 32-bit result. The control unit returns that result through the write-back mux to the register-file write port. It stalls the pipeline via `busy` while iterating.

## Interface

Parameters:
- `XLEN`, default 32: operand/result width. Only 32 is supported.

Ports:
- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request pulse; sampled on rising `clk` edges.
- `op`  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`  input  XLEN  rs1 operand (register-file RD1).
- `b`  input  XLEN  rs2 operand (register-file RD2).
- `busy`  output  1  high while iterating; the control unit stalls the PC and register-file write-enable.
- `done`  output  1  one-cycle pulse when `result` becomes valid.
- `result`  output  XLEN  final value; held until the next `done`.

## Operation

- Reset values: state=IDLE, `busy`=0, `done`=0, `result`=0, and all internal registers 0.
- The FSM has three states:
  - IDLE: `busy`=0.
  - CALC: `busy`=1.
  - DONE: `busy`=0, `done`=1.
- Start acceptance:
  - `start` is accepted in IDLE or DONE (i.e. whenever `busy`=0).
  - In CALC it is ignored. Nothing is queued.
- On acceptance:
  - Latch `op`, `a`, `b` and the sign flags.
  - Latch |a| and |b| according to operand signedness:
    - MULH: both signed.
    - MULHSU: a signed, b unsigned.
    - MULHU, DIVU, REMU, MUL: unsigned magnitudes. MUL's low word is sign-agnostic.
    - DIV, REM: both signed.
  - Clear the 5-bit iteration counter.
  - Go to CALC, except for the special cases below.
- Operand inputs are don't-care after acceptance.
- Special cases go IDLE/DONE→DONE directly:
  - Divide by zero (b==0, op[2]=1):
    - DIV/DIVU → 0xFFFFFFFF.
    - REM/REMU → a.
  - Signed overflow (DIV/REM, a==0x80000000, b==0xFFFFFFFF):
    - DIV → 0x80000000.
    - REM → 0.
- CALC, multiply: radix-2 shift-add over a 64-bit accumulator, one multiplier bit per cycle, 32 cycles.
- CALC, divide: restoring division, one quotient bit per cycle, 32 cycles. The 33-bit trial subtract is on the remainder.
- CALC ends when the counter reaches 31; on that edge go to DONE and load `result`.
- Sign correction is applied when loading `result`:
  - Negate the 64-bit product if the operand signs differ (signed operands only).
  - Negate the quotient if the signs of a and b differ.
  - The remainder takes the sign of a.
- Result selection:
  - MUL → product[31:0].
  - MULH, MULHSU, MULHU → product[63:32].
- DONE lasts one cycle, then returns to IDLE unless a new `start` is accepted on that edge.
- Reset asserted in any state returns to IDLE immediately, with `busy`, `done` and `result` cleared. The in-flight operation is discarded.

## Timing

- Let the accept edge be E0.
- Normal op:
  - `busy`=1 from E0 through E32.
  - DONE is entered at E32, so `done`=1 and `result` is valid for the cycle E32–E33.
  - Latency is 32 cycles from accept to `done`.
- Special case: DONE is entered at E0, so `done` is high for E0–E1. Latency is 1 cycle.
- `result` changes only on the edge that enters DONE. It is stable at all other times.
- Back-to-back: a `start` seen at the edge leaving DONE is accepted, so there are zero idle cycles between ops.
- `busy` and `done` are never high simultaneously.

## Test plan

- MUL, a=5, b=4, start at E0 → `busy` high E0–E32, `done` pulse at E32, `result`=0x00000014.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV −7/2 → 0xFFFFFFFD. REM −7%2 → 0xFFFFFFFF. DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC. Each takes 32 cycles.
- Special cases, each with `done` at E0 and `busy` never high:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 0x00000005.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- During CALC of MUL 5×4, pulse `start` with DIV 9/3 and toggle `a`/`b` → ignored; `result`=0x14. Then DIV issued on the DONE edge → `result`=3 exactly 32 cycles later.
- Assert `rst` asynchronously at E10 of a DIV → `busy`, `done` and `result` go to 0 without a clock. After release, a MUL 6×7 completes normally with `result`=0x2A.
